// File: rtl/gray_counter_moore_fsm.sv
// Gray-code counter built as a Moore FSM.
// WIDTH == 2 : four named one-hot states S0..S3, y decoded from the state.
// WIDTH  > 2 : binary index register, y = n ^ (n >> 1) decoded from it.
// y is a pure decode of the state register, so it changes on the same edge
// that advances the state and never depends combinationally on arst or clk.
module gray_counter_moore_fsm #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             arst,
  output logic [WIDTH-1:0] y
);

  if (WIDTH == 2) begin : g_w2
    // One-hot encoding leaves twelve illegal 4-bit patterns; all of them
    // (and any unknown value) fall into the default arm and recover to S0.
    typedef enum logic [3:0] {
      S0 = 4'b0001,
      S1 = 4'b0010,
      S2 = 4'b0100,
      S3 = 4'b1000
    } state_t;

    logic [3:0] state_p0;
    logic [3:0] state_nxt;

    // State register; asynchronous reset forces S0 immediately.
    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        state_p0 <= S0;
      end else begin
        state_p0 <= state_nxt;
      end
    end

    // Next-state logic: S0 -> S1 -> S2 -> S3 -> S0, anything else -> S0.
    always_comb begin
      state_nxt = S0;
      case (state_p0)
        S0:      state_nxt = S1;
        S1:      state_nxt = S2;
        S2:      state_nxt = S3;
        S3:      state_nxt = S0;
        default: state_nxt = S0;
      endcase
    end

    // Moore output decode: S0=00, S1=01, S2=11, S3=10; illegal states read 00.
    always_comb begin
      y = '0;
      case (state_p0)
        S0:      y = 2'b00;
        S1:      y = 2'b01;
        S2:      y = 2'b11;
        S3:      y = 2'b10;
        default: y = 2'b00;
      endcase
    end
  end else begin : g_bin
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] idx_p0;
    logic [WIDTH-1:0] idx_nxt;

    // Index register; asynchronous reset forces index 0 immediately.
    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        idx_p0 <= '0;
      end else begin
        idx_p0 <= idx_nxt;
      end
    end

    // Next index: natural modulo-2^WIDTH increment, wrap from all-ones to 0.
    always_comb begin
      idx_nxt = '0;
      idx_nxt = idx_p0 + ONE;
    end

    // Moore output decode: binary index to reflected Gray code.
    always_comb begin
      y = '0;
      y = bin2gray(idx_p0);
    end
  end

endmodule

// File: tb/tb_gray_counter_moore_fsm.sv
// Directed bench for gray_counter_moore_fsm, WIDTH=2 and WIDTH=4 side by side.
// Expected values come from an independent index model converted to Gray code,
// queued before each clock edge and popped after it.
module tb_gray_counter_moore_fsm;

  logic       clk = 1'b0;
  logic       arst2;
  logic       arst4;
  logic [1:0] y2;
  logic [3:0] y4;

  int checks = 0;
  int errors = 0;

  int m2 = 0;
  int m4 = 0;
  bit inj2 = 1'b0;
  logic [3:0] prev4;

  logic [15:0] q2[$];
  logic [15:0] q4[$];

  always #5 clk = ~clk;

  gray_counter_moore_fsm #(.WIDTH(2)) dut2 (.clk(clk), .arst(arst2), .y(y2));
  gray_counter_moore_fsm #(.WIDTH(4)) dut4 (.clk(clk), .arst(arst4), .y(y4));

  function automatic logic [15:0] gray(input int v);
    logic [15:0] b;
    b = v[15:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model for the coming edge, queue expectations, take the edge,
  // then pop and compare both instances.
  task automatic tick(input string tag);
    m2 = (arst2 || inj2) ? 0 : (m2 + 1) % 4;
    inj2 = 1'b0;
    m4 = arst4 ? 0 : (m4 + 1) % 16;
    q2.push_back(gray(m2));
    q4.push_back(gray(m4));
    @(posedge clk);
    #1;
    check({tag, "/y2"}, {14'b0, y2}, q2.pop_front());
    check({tag, "/y4"}, {12'b0, y4}, q4.pop_front());
  endtask

  initial begin
    // Reset held from time 0 to 30 ns, edges at 5, 15, 25 must not advance.
    arst2 = 1'b1;
    arst4 = 1'b1;
    #1;
    check("reset_y2", {14'b0, y2}, 16'h0);
    check("reset_y4", {12'b0, y4}, 16'h0);
    for (int i = 0; i < 3; i++) tick("in_reset");

    // Release at 30 ns; y stays zero until the 35 ns edge, which gives 01.
    #4;
    arst2 = 1'b0;
    arst4 = 1'b0;
    #1;
    check("post_release_y2", {14'b0, y2}, 16'h0);
    check("post_release_y4", {12'b0, y4}, 16'h0);
    tick("first_edge");
    check("first_edge_y2_is_01", {14'b0, y2}, 16'h0001);

    // Free run to 20 edges from reset; WIDTH=4 crosses 1000 -> 0000.
    for (int k = 2; k <= 20; k++) begin
      prev4 = y4;
      tick("run");
      check("run_onebit_y4", 16'($countones(y4 ^ prev4)), 16'd1);
    end

    // Bring WIDTH=2 to 11, then assert reset between edges.
    tick("to_11");
    tick("to_11");
    check("before_async_y2", {14'b0, y2}, 16'h0003);
    #3;
    arst2 = 1'b1;
    m2 = 0;
    #1;
    check("async_reset_y2", {14'b0, y2}, 16'h0);
    #1;
    arst2 = 1'b0;
    tick("after_async");
    check("after_async_y2_is_01", {14'b0, y2}, 16'h0001);

    // Hold WIDTH=4 reset across five rising edges.
    #3;
    arst4 = 1'b1;
    m4 = 0;
    #1;
    check("async_reset_y4", {12'b0, y4}, 16'h0);
    for (int i = 0; i < 5; i++) tick("hold_reset");
    #3;
    arst4 = 1'b0;
    tick("after_hold");
    check("after_hold_y4_is_0001", {12'b0, y4}, 16'h0001);

    // Plant an illegal one-hot pattern; one edge must return to S0.
    #3;
    force dut2.g_w2.state_p0 = 4'b0110;
    #1;
    release dut2.g_w2.state_p0;
    inj2 = 1'b1;
    tick("illegal_recover");
    check("illegal_recover_y2", {14'b0, y2}, 16'h0);
    tick("after_illegal");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
